// File: rtl/press_classifier.sv
// Classifies debounced button presses as short or long and emits auto-repeat
// pulses while a long press is held. All pulse outputs are registered.
module press_classifier #(
  parameter int LONG_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_debounced,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("press_classifier: LONG_CYCLES must be >= 2");
  end
  if (LONG_CYCLES > (2 ** CNT_W) - 1 || REPEAT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_width
    $error("press_classifier: CNT_W too narrow for LONG_CYCLES/REPEAT_CYCLES");
  end

  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESS, LONG} state_t;

  localparam logic [CNT_W:0] LONG_TGT  = (CNT_W + 1)'(LONG_CYCLES);
  localparam logic [CNT_W:0] REP_TGT   = (CNT_W + 1)'(REPEAT_CYCLES);
  localparam bit             REPEAT_EN = (REPEAT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic             short_d, long_d, rep_d, held_d;
  logic [7:0]       count_d;

  // One bit wider so the cnt+1 comparison cannot wrap.
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    count_d = press_count;

    unique case (state_q)
      LOCKOUT: begin
        if (!pb_debounced) state_d = IDLE;
      end
      IDLE: begin
        if (pb_debounced) begin
          state_d = PRESS;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      PRESS: begin
        if (pb_debounced) begin
          if (cnt_inc == LONG_TGT) begin
            long_d  = 1'b1;
            state_d = LONG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end else begin
          short_d = 1'b1;
          count_d = press_count + 8'd1;
          state_d = IDLE;
        end
      end
      LONG: begin
        if (pb_debounced) begin
          if (REPEAT_EN && cnt_inc == REP_TGT) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    held_d = (state_d == PRESS) || (state_d == LONG);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOCKOUT;
      cnt_q        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
      press_count  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_press  <= short_d;
      long_press   <= long_d;
      repeat_pulse <= rep_d;
      held         <= held_d;
      press_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Random and directed stimulus for press_classifier, checked against a
// press-length model (count of consecutive high samples per press).
module tb_press_classifier;

  localparam int L = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb  = 1'b1;
  logic       short_press, long_press, repeat_pulse, held;
  logic [7:0] press_count;
  logic       short_nr, long_nr, repeat_nr, held_nr;
  logic [7:0] count_nr;

  press_classifier #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .pb_debounced(pb),
    .short_press(short_press), .long_press(long_press), .repeat_pulse(repeat_pulse),
    .held(held), .press_count(press_count)
  );

  press_classifier #(.LONG_CYCLES(L), .REPEAT_CYCLES(0), .CNT_W(16)) u_dut_norep (
    .clk(clk), .rst(rst), .pb_debounced(pb),
    .short_press(short_nr), .long_press(long_nr), .repeat_pulse(repeat_nr),
    .held(held_nr), .press_count(count_nr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: lockout flag plus length of the current press.
  bit m_locked;
  int m_n;
  int m_count;
  bit e_short, e_long, e_rep;

  int n_short, n_long, n_rep, n_long_nr, n_rep_nr, n_held;

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_rep = 0; n_long_nr = 0; n_rep_nr = 0; n_held = 0;
  endtask

  task automatic step(input logic b);
    pb = b;
    @(posedge clk);
    e_short = 0; e_long = 0; e_rep = 0;
    if (m_locked) begin
      if (!b) m_locked = 0;
    end else if (b) begin
      m_n++;
      e_long = (m_n == L);
      e_rep  = (m_n > L) && ((m_n - L) % R == 0);
    end else begin
      if (m_n > 0 && m_n < L) begin
        e_short = 1;
        m_count = (m_count + 1) % 256;
      end
      m_n = 0;
    end
    #1;
    check("short", short_press, e_short);
    check("long", long_press, e_long);
    check("repeat", repeat_pulse, e_rep);
    check("held", held, m_n > 0);
    check("count", press_count, m_count);
    check("exclusive", (int'(short_press) + int'(long_press) + int'(repeat_pulse)) <= 1, 1);
    check("nr_short", short_nr, e_short);
    check("nr_long", long_nr, e_long);
    check("nr_repeat", repeat_nr, 0);
    check("nr_held", held_nr, m_n > 0);
    check("nr_count", count_nr, m_count);
    n_short   += int'(short_press);
    n_long    += int'(long_press);
    n_rep     += int'(repeat_pulse);
    n_long_nr += int'(long_nr);
    n_rep_nr  += int'(repeat_nr);
    n_held    += int'(held);
  endtask

  // Asserts reset asynchronously, checks the immediate clear, releases on a falling edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    m_locked = 1; m_n = 0; m_count = 0;
    check("rst_short", short_press, 0);
    check("rst_long", long_press, 0);
    check("rst_repeat", repeat_pulse, 0);
    check("rst_held", held, 0);
    check("rst_count", press_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int len, input int gap);
    for (int i = 0; i < len; i++) step(1'b1);
    for (int i = 0; i < gap; i++) step(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Button held through reset must never fire.
    pb = 1'b1;
    apply_reset();
    clear_counts();
    for (int i = 0; i < 12; i++) step(1'b1);
    check("t1_no_pulses", n_short + n_long + n_rep, 0);
    check("t1_held", n_held, 0);
    step(1'b0);

    clear_counts();
    press(3, 1);
    check("t2_short", n_short, 1);
    check("t2_long", n_long, 0);
    check("t2_held_cycles", n_held, 3);
    check("t2_count", press_count, 1);

    clear_counts();
    press(7, 1);
    check("t3_short7", n_short, 1);
    check("t3_long7", n_long, 0);
    clear_counts();
    press(8, 1);
    check("t3_short8", n_short, 0);
    check("t3_long8", n_long, 1);

    clear_counts();
    press(21, 1);
    check("t4_long", n_long, 1);
    check("t4_repeat", n_rep, 3);
    check("t4_short", n_short, 0);
    check("t4_held_cycles", n_held, 21);

    // Reset in the middle of a long hold aborts it.
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b1);
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b0);
    press(2, 1);
    check("t5_short", n_short, 1);
    check("t5_long", n_long, 1);
    check("t5_count", press_count, 1);

    apply_reset();
    step(1'b0);
    clear_counts();
    for (int i = 0; i < 256; i++) press(2, 2);
    check("t6_shorts", n_short, 256);
    check("t6_wrap", press_count, 0);

    clear_counts();
    press(40, 1);
    check("t7_nr_long", n_long_nr, 1);
    check("t7_nr_repeat", n_rep_nr, 0);
    check("t7_repeat", n_rep, (40 - L) / R);

    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 9) == 0) begin
        pb = 1'(($urandom_range(0, 1)));
        apply_reset();
      end
      press($urandom_range(1, 26), $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
